conv3x3_slow_ctrl: RTL and testbench

Sequencer and serial MAC for the slow 3x3 convolution path. It drives the 4-bit select of the external 9:1 data and weight muxes through cnt = 0..8. Each cycle it accumulates one data×weight product, then applies shift, optional ReLU and saturation. Upstream (window buffer) hands over through a valid/ready handshake; the result leaves through a valid/ready handshake to the output writer.

---
 rtl/conv3x3_slow_ctrl_pkg.sv | 19 +
 rtl/conv3x3_slow_ctrl_postproc.sv | 38 +++
 rtl/conv3x3_slow_ctrl.sv | 111 +++++++++++
 tb/tb_conv3x3_slow_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_slow_ctrl_pkg.sv
// Shared types and constants for the slow 3x3 convolution path.
// State encoding, tap count and default datapath widths.
package conv_slow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         TAPS     = 9;
  localparam logic [3:0] CNT_LAST = 4'(TAPS - 1);

  localparam int DEF_DW   = 8;
  localparam int DEF_WW   = 8;
  localparam int DEF_ACCW = 20;
  localparam int OUT_W    = 8;

endpackage

// File: rtl/conv3x3_slow_ctrl_postproc.sv
// conv_postproc: arithmetic shift, optional ReLU and saturation to 8 bits.
// Ports: acc_i (signed accumulator) -> data_o (8-bit result).
module conv_postproc
  import conv_slow_pkg::*;
#(
  parameter int ACCW  = DEF_ACCW,
  parameter int SHIFT = 0,
  parameter int RELU  = 1
) (
  input  logic signed [ACCW-1:0]  acc_i,
  output logic        [OUT_W-1:0] data_o
);

  localparam logic signed [ACCW-1:0] U_MAX = ACCW'(255);
  localparam logic signed [ACCW-1:0] S_MAX = ACCW'(127);
  localparam logic signed [ACCW-1:0] S_MIN = ACCW'(-128);

  logic signed [ACCW-1:0] s;

  always_comb begin
    s      = acc_i >>> SHIFT;
    data_o = s[OUT_W-1:0];
    if (RELU != 0) begin
      if (s < 0) begin
        data_o = '0;
      end else if (s > U_MAX) begin
        data_o = 8'hFF;
      end
    end else begin
      if (s < S_MIN) begin
        data_o = 8'h80;
      end else if (s > S_MAX) begin
        data_o = 8'h7F;
      end
    end
  end

endmodule

// File: rtl/conv3x3_slow_ctrl.sv
// conv3x3_slow_ctrl: sequencer + serial MAC for the slow 3x3 conv path.
// Ports: in_valid/in_ready accept, cnt drives external 9:1 muxes
// (data, weight), out_valid/out_ready result with out_data/out_acc.
module conv3x3_slow_ctrl
  import conv_slow_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int WW    = DEF_WW,
  parameter int ACCW  = DEF_ACCW,
  parameter int SHIFT = 0,
  parameter int RELU  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [3:0]             cnt,
  input  logic [DW-1:0]          data,
  input  logic signed [WW-1:0]   weight,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic signed [ACCW-1:0] out_acc
);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]       odata_q, odata_d;

  logic signed [DW:0]     data_x;
  logic signed [DW+WW:0]  prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc_sum;
  logic [OUT_W-1:0]       pp_data;

  // data is unsigned: add a zero MSB so the signed multiply is exact
  assign data_x   = {1'b0, data};
  assign prod     = data_x * weight;
  assign prod_ext = ACCW'(prod);
  assign acc_sum  = acc_q + prod_ext;

  // post-process the final sum so the result lands with DONE
  conv_postproc #(
    .ACCW  (ACCW),
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_pp (
    .acc_i  (acc_sum),
    .data_o (pp_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      odata_q <= odata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    odata_d = odata_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          odata_d = pp_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // in_ready gated by rst so nothing is taken while reset is held
  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign cnt       = cnt_q;
  assign out_data  = odata_q;
  assign out_acc   = acc_q;

endmodule

// File: tb/tb_conv3x3_slow_ctrl.sv
// Bench for conv3x3_slow_ctrl: two instances (RELU=0/SHIFT=0 and
// RELU=1/SHIFT=2) driven by the same window, directed vectors.
module tb_conv3x3_slow_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;

  logic [7:0]        win [9];
  logic signed [7:0] wgt [9];

  logic              in_ready_a, busy_a, out_valid_a;
  logic [3:0]        cnt_a;
  logic [7:0]        data_a, out_data_a;
  logic signed [7:0] weight_a;
  logic signed [19:0] out_acc_a;

  logic              in_ready_b, busy_b, out_valid_b;
  logic [3:0]        cnt_b;
  logic [7:0]        data_b, out_data_b;
  logic signed [7:0] weight_b;
  logic signed [19:0] out_acc_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // external 9:1 muxes, default 0 out of range
  always_comb begin
    data_a   = '0;
    weight_a = '0;
    data_b   = '0;
    weight_b = '0;
    if (cnt_a < 4'd9) begin
      data_a   = win[cnt_a];
      weight_a = wgt[cnt_a];
    end
    if (cnt_b < 4'd9) begin
      data_b   = win[cnt_b];
      weight_b = wgt[cnt_b];
    end
  end

  conv3x3_slow_ctrl #(.SHIFT(0), .RELU(0)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .cnt       (cnt_a),
    .data      (data_a),
    .weight    (weight_a),
    .busy      (busy_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a),
    .out_acc   (out_acc_a)
  );

  conv3x3_slow_ctrl #(.SHIFT(2), .RELU(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .cnt       (cnt_b),
    .data      (data_b),
    .weight    (weight_b),
    .busy      (busy_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_data  (out_data_b),
    .out_acc   (out_acc_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int mode);
    for (int i = 0; i < 9; i++) begin
      unique case (mode)
        0: begin win[i] = 8'd1;      wgt[i] = 8'sd1;    end
        1: begin win[i] = 8'(i);     wgt[i] = 8'sd1;    end
        2: begin win[i] = 8'd255;    wgt[i] = -8'sd128; end
        3: begin win[i] = 8'd128;    wgt[i] = 8'sd1;    end
        4: begin win[i] = 8'd100;    wgt[i] = (i == 0) ? 8'sd1 : 8'sd0; end
        5: begin win[i] = 8'(i);     wgt[i] = 8'(i);    end
        6: begin win[i] = 8'(i);     wgt[i] = -8'sd1;   end
        default: begin win[i] = 8'd7; wgt[i] = 8'sd3;   end
      endcase
    end
  endtask

  // called #1 after a posedge with the block idle
  task automatic run_txn(input string nm, input int e_acc,
                         input int e_da, input int e_db,
                         input int hold);
    int n;
    int bad;
    int sd;
    int sa;
    chk({nm, ".in_ready"}, int'(in_ready_a), 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n   = 0;
    bad = 0;
    while (!out_valid_a && n < 30) begin
      if (int'(cnt_a) != n) bad++;
      @(posedge clk); #1;
      n++;
    end
    // accept cycle is T; out_valid seen 9 edges later = cycle T+10
    chk({nm, ".latency"}, n, 9);
    chk({nm, ".cnt_seq"}, bad, 0);
    chk({nm, ".cnt_done"}, int'(cnt_a), 0);
    chk({nm, ".acc_a"}, int'(out_acc_a), e_acc);
    chk({nm, ".acc_b"}, int'(out_acc_b), e_acc);
    chk({nm, ".data_a"}, int'(out_data_a), e_da);
    chk({nm, ".data_b"}, int'(out_data_b), e_db);
    sd = int'(out_data_a);
    sa = int'(out_acc_a);
    for (int i = 0; i < hold; i++) begin
      if (i == 2) in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    if (hold > 0) begin
      chk({nm, ".hold_valid"}, int'(out_valid_a), 1);
      chk({nm, ".hold_data"}, int'(out_data_a), sd);
      chk({nm, ".hold_acc"}, int'(out_acc_a), sa);
      chk({nm, ".hold_rdy"}, int'(in_ready_a), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, ".ov_drop"}, int'(out_valid_a), 0);
    chk({nm, ".idle"}, int'(busy_a), 0);
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    load(0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst.busy", int'(busy_a), 0);
    chk("rst.ovalid", int'(out_valid_a), 0);
    chk("rst.cnt", int'(cnt_a), 0);
    chk("rst.data", int'(out_data_a), 0);
    chk("rst.acc", int'(out_acc_a), 0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", int'(in_ready_a), 1);
    @(posedge clk); #1;

    load(0); run_txn("ones",   9,       9,   2,   0);
    load(1); run_txn("ramp",   36,      36,  9,   0);
    load(2); run_txn("neg",    -293760, 128, 0,   0);
    load(3); run_txn("sat",    1152,    127, 255, 0);
    load(4); run_txn("tap0",   100,     100, 25,  0);
    load(5); run_txn("bp",     204,     127, 51,  5);
    load(6); run_txn("negmix", -36,     220, 0,   0);

    // abort mid-RUN with an asynchronous reset
    load(7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (cnt_a != 4'd4 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort.reach4", int'(cnt_a), 4);
    #3;
    rst = 1'b1;
    #1;
    chk("abort.busy", int'(busy_a), 0);
    chk("abort.cnt", int'(cnt_a), 0);
    chk("abort.ovalid", int'(out_valid_a), 0);
    chk("abort.busy_b", int'(busy_b), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    load(0); run_txn("post", 9, 9, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
